// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory initiator.
// Issues one load/store at a time on a req/gnt/rvalid bus and stalls the
// pipeline until the access completes. The raw read word is presented on
// RamDataM; WB does the sub-word realignment using AluOutM[1:0].
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of silently clearing the offending low address bits.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; a new access latches bus fields here
// REQ   | BusReq high, fields frozen, waiting for BusGnt
// WAIT  | read granted, waiting for BusRValid (with optional timeout)
// DONE  | single cycle with the stall released so MEM/WB captures
module mem_access_unit #(
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        FlushM,
  input  logic [31:0] AluOutM,
  input  logic [31:0] StoreDataM,
  output logic [31:0] RamDataM,
  output logic        MemStall,
  output logic        MemErrM,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusWStrb,
  output logic [31:0] BusWData,
  input  logic        BusGnt,
  input  logic        BusRValid,
  input  logic [31:0] BusRData,
  input  logic        BusErr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Counter only has to reach TIMEOUT-1 before the timeout fires.
  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    strb_q, strb_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          access;
  logic          trap;
  logic          timeout_hit;
  logic [3:0]    strb_nxt;
  logic [31:0]   wdata_nxt;

  assign access = (MemReadM | MemWriteM) & ~FlushM;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((MemSizeM == 2'b01) & AluOutM[0]) |
                      (MemSizeM[1] & (|AluOutM[1:0]));
  assign trap = (state_q == S_IDLE) & access & misaligned;
`else
  // Misaligned low bits simply fall away: the half strobe ignores addr[0]
  // and the word strobe ignores addr[1:0], and BusAddr is always word-aligned.
  assign trap = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Byte-lane strobes and lane-replicated store data for the incoming access.
  always_comb begin
    strb_nxt  = 4'b1111;
    wdata_nxt = StoreDataM;
    case (MemSizeM)
      2'b00: begin
        strb_nxt  = 4'b0001 << AluOutM[1:0];
        wdata_nxt = {4{StoreDataM[7:0]}};
      end
      2'b01: begin
        strb_nxt  = 4'b0011 << {AluOutM[1], 1'b0};
        wdata_nxt = {2{StoreDataM[15:0]}};
      end
      default: begin
        strb_nxt  = 4'b1111;
        wdata_nxt = StoreDataM;
      end
    endcase
  end

  // Next-state logic for the access sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (access && !trap) begin
          addr_d  = {AluOutM[31:2], 2'b00};
          we_d    = MemWriteM;
          strb_d  = strb_nxt;
          wdata_d = wdata_nxt;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (BusGnt) begin
          if (we_q) begin
            err_d   = BusErr;
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (BusRValid) begin
          rdata_d = BusErr ? RESET_RDATA : BusRData;
          err_d   = BusErr;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          rdata_d = RESET_RDATA;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        // DONE: the pipeline advances on this edge, so never reissue.
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= RESET_RDATA;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
    end
  end

  // Outputs: bus fields come straight from registers; stall and trap are
  // combinational so a trapped access never stalls and reports in-cycle.
  assign BusReq   = (state_q == S_REQ);
  assign BusWe    = we_q;
  assign BusAddr  = addr_q;
  assign BusWStrb = strb_q;
  assign BusWData = wdata_q;
  assign RamDataM = rdata_q;
  assign MemErrM  = err_q | trap;
  assign MemStall = ((state_q == S_IDLE) & access & ~trap) |
                    (state_q == S_REQ) | (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written reset-in-WAIT
// sequence, and randomized accesses against a timeline-level reference model.
module tb_mem_access_unit;

  localparam int TMO = 4;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM, FlushM;
  logic [1:0]  MemSizeM;
  logic [31:0] AluOutM, StoreDataM;
  logic [31:0] RamDataM;
  logic        MemStall, MemErrM;
  logic        BusReq, BusWe;
  logic [31:0] BusAddr, BusWData;
  logic [3:0]  BusWStrb;
  logic        BusGnt, BusRValid, BusErr;
  logic [31:0] BusRData;

  int checks   = 0;
  int failures = 0;
  logic [31:0] ram_model;

  mem_access_unit #(.TIMEOUT(TMO), .RESET_RDATA(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
    .FlushM(FlushM), .AluOutM(AluOutM), .StoreDataM(StoreDataM),
    .RamDataM(RamDataM), .MemStall(MemStall), .MemErrM(MemErrM),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr),
    .BusWStrb(BusWStrb), .BusWData(BusWData),
    .BusGnt(BusGnt), .BusRValid(BusRValid), .BusRData(BusRData), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the access description.
  function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
    int lane;
    lane = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << lane);
    if (sz == 2'd1) return 4'(3 << ((lane / 2) * 2));
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
  endfunction

  task automatic idle_inputs();
    MemReadM = 0; MemWriteM = 0; MemSizeM = 0; FlushM = 0;
    AluOutM = 0; StoreDataM = 0;
    BusGnt = 0; BusRValid = 0; BusErr = 0; BusRData = 0;
  endtask

  // Runs one MEM-stage access from IDLE back to IDLE, playing the bus side.
  // Entry/exit: 1 time unit after a rising edge.
  task automatic run_access(
    input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] addr,
    input logic [31:0] sd, input logic fl, input int gd, input int rv,
    input logic [31:0] rdata, input logic err,
    output int stall_cnt, output logic [31:0] o_addr, output logic [3:0] o_strb,
    output logic [31:0] o_wdata, output logic o_we);
    bit acc, trp, tmo;
    int nwait;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    acc = (rd | wr) & ~fl;
    trp = TRAP_EN && acc && m_misaligned(sz, addr);
    e_addr = addr & 32'hFFFF_FFFC;
    e_strb = m_strb(sz, addr);
    e_wdata = m_wdata(sz, sd);
    stall_cnt = 0; o_addr = 0; o_strb = 0; o_wdata = 0; o_we = 0;

    MemReadM = rd; MemWriteM = wr; MemSizeM = sz; AluOutM = addr;
    StoreDataM = sd; FlushM = fl; BusGnt = 0; BusRValid = 0; BusErr = 0;
    @(negedge clk);
    chk("idle_stall", MemStall, acc & ~trp);
    chk("idle_req", BusReq, 0);
    chk("idle_err", MemErrM, trp);
    if (MemStall) stall_cnt++;
    @(posedge clk); #1;

    if (!acc || trp) begin
      idle_inputs();
      @(negedge clk);
      chk("noacc_req", BusReq, 0);
      chk("noacc_stall", MemStall, 0);
      chk("noacc_err", MemErrM, 0);
      chk("noacc_ram", RamDataM, ram_model);
      @(posedge clk); #1;
      return;
    end

    // Pipeline inputs other than the command are scrambled: the unit must
    // have latched everything it needs, and flush must be ignored now.
    for (int k = 0; k <= gd; k++) begin
      AluOutM = $urandom; StoreDataM = $urandom; MemSizeM = 2'($urandom);
      FlushM = 1'($urandom % 2);
      BusGnt = (k == gd);
      BusErr = (k == gd && wr) ? err : 1'($urandom % 2);
      @(negedge clk);
      chk("req_req", BusReq, 1);
      chk("req_stall", MemStall, 1);
      chk("req_err", MemErrM, 0);
      chk("req_addr", BusAddr, e_addr);
      chk("req_strb", BusWStrb, e_strb);
      chk("req_wdata", BusWData, e_wdata);
      chk("req_we", BusWe, wr);
      if (MemStall) stall_cnt++;
      o_addr = BusAddr; o_strb = BusWStrb; o_wdata = BusWData; o_we = BusWe;
      @(posedge clk); #1;
    end
    BusGnt = 0; BusErr = 0;

    tmo = 0;
    if (!wr) begin
      tmo = (TMO != 0) && (rv >= TMO);
      nwait = tmo ? TMO : rv + 1;
      for (int j = 0; j < nwait; j++) begin
        BusRValid = !tmo && (j == rv);
        BusRData = BusRValid ? rdata : $urandom;
        BusErr = BusRValid ? err : 1'b0;
        @(negedge clk);
        chk("wait_stall", MemStall, 1);
        chk("wait_req", BusReq, 0);
        chk("wait_err", MemErrM, 0);
        if (MemStall) stall_cnt++;
        @(posedge clk); #1;
      end
      BusRValid = 0; BusErr = 0;
      ram_model = (tmo || err) ? 32'h0 : rdata;
    end

    @(negedge clk);
    chk("done_stall", MemStall, 0);
    chk("done_req", BusReq, 0);
    chk("done_err", MemErrM, tmo | err);
    chk("done_ram", RamDataM, ram_model);
    @(posedge clk); #1;

    idle_inputs();
    if (tmo) begin
      BusRValid = 1; BusRData = $urandom;
    end
    @(negedge clk);
    chk("post_req", BusReq, 0);
    chk("post_stall", MemStall, 0);
    chk("post_err", MemErrM, 0);
    @(posedge clk); #1;
    BusRValid = 0;
    @(negedge clk);
    chk("post_ram", RamDataM, ram_model);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic rd; logic wr; logic [1:0] sz; logic [31:0] addr; logic [31:0] sd;
    logic fl; int gd; int rv; logic [31:0] rdata; logic err;
    logic [31:0] e_addr; logic [3:0] e_strb; logic [31:0] e_wdata; logic e_we;
    int e_stall; logic [31:0] e_ram;
  } vec_t;

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] addr,
    input logic [31:0] sd, input logic fl, input int gd, input int rv,
    input logic [31:0] rdata, input logic err, input logic [31:0] e_addr,
    input logic [3:0] e_strb, input logic [31:0] e_wdata, input logic e_we,
    input int e_stall, input logic [31:0] e_ram);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.addr = addr; v.sd = sd; v.fl = fl;
    v.gd = gd; v.rv = rv; v.rdata = rdata; v.err = err;
    v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_we = e_we;
    v.e_stall = e_stall; v.e_ram = e_ram;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int sc;
    logic [31:0] oa, ow;
    logic [3:0]  os;
    logic        owe;

    //           rd wr sz    addr         sd           fl gd rv rdata         err  e_addr       e_strb   e_wdata      we stall e_ram
    vecs.push_back(mk(1, 0, 2'd2, 32'h100, 32'h0,        0, 1, 1, 32'hDEADBEEF, 0, 32'h100, 4'hF,    32'h0,        0, 5, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 2'd0, 32'h203, 32'hA5,       0, 0, 0, 32'h0,        0, 32'h200, 4'b1000, 32'hA5A5A5A5, 1, 2, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 2'd1, 32'h002, 32'h1234,     0, 4, 0, 32'h0,        0, 32'h000, 4'b1100, 32'h12341234, 1, 6, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 2'd2, 32'h300, 32'h0,        0, 0, 9, 32'h0,        0, 32'h300, 4'hF,    32'h0,        0, 6, 32'h0));
    vecs.push_back(mk(1, 0, 2'd2, 32'h040, 32'h0,        0, 0, 0, 32'h11223344, 0, 32'h040, 4'hF,    32'h0,        0, 3, 32'h11223344));
    vecs.push_back(mk(1, 0, 2'd2, 32'h080, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,   4'h0,    32'h0,        0, 0, 32'h11223344));
    vecs.push_back(mk(1, 1, 2'd2, 32'h008, 32'hCAFEF00D, 0, 2, 0, 32'h0,        0, 32'h008, 4'hF,    32'hCAFEF00D, 1, 4, 32'h11223344));
    vecs.push_back(mk(0, 1, 2'd0, 32'h001, 32'h77711,    0, 0, 0, 32'h0,        1, 32'h000, 4'b0010, 32'h11111111, 1, 2, 32'h11223344));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk(1, 0, 2'd1, 32'h101, 32'h0,        0, 0, 0, 32'h55667788, 0, 32'h0,   4'h0,    32'h0,        0, 0, 32'h11223344));
`else
    vecs.push_back(mk(1, 0, 2'd1, 32'h101, 32'h0,        0, 0, 0, 32'h55667788, 0, 32'h100, 4'b0011, 32'h0,        0, 3, 32'h55667788));
`endif
    vecs.push_back(mk(1, 0, 2'd2, 32'h010, 32'h0,        0, 0, 0, 32'hFFFF0000, 1, 32'h010, 4'hF,    32'h0,        0, 3, 32'h0));
    vecs.push_back(mk(0, 1, 2'd3, 32'h020, 32'h89ABCDEF, 0, 1, 0, 32'h0,        0, 32'h020, 4'hF,    32'h89ABCDEF, 1, 3, 32'h0));
    vecs.push_back(mk(1, 0, 2'd0, 32'h302, 32'h0,        0, 0, 2, 32'hA1B2C3D4, 0, 32'h300, 4'b0100, 32'h0,        0, 5, 32'hA1B2C3D4));

    idle_inputs();
    rst = 1;
    ram_model = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ram", RamDataM, 32'h0);
    chk("rst_req", BusReq, 0);
    chk("rst_we", BusWe, 0);
    chk("rst_addr", BusAddr, 0);
    chk("rst_strb", BusWStrb, 0);
    chk("rst_wdata", BusWData, 0);
    chk("rst_err", MemErrM, 0);
    chk("rst_stall", MemStall, 0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].sd,
                 vecs[i].fl, vecs[i].gd, vecs[i].rv, vecs[i].rdata, vecs[i].err,
                 sc, oa, os, ow, owe);
      chk($sformatf("vec%0d_stall", i), sc, vecs[i].e_stall);
      chk($sformatf("vec%0d_addr", i), oa, vecs[i].e_addr);
      chk($sformatf("vec%0d_strb", i), os, vecs[i].e_strb);
      chk($sformatf("vec%0d_wdata", i), ow, vecs[i].e_wdata);
      chk($sformatf("vec%0d_we", i), owe, vecs[i].e_we);
      chk($sformatf("vec%0d_ram", i), RamDataM, vecs[i].e_ram);
    end

    // Reset while a read is parked in WAIT.
    MemReadM = 1; MemSizeM = 2'd2; AluOutM = 32'h80;
    @(negedge clk); @(posedge clk); #1;
    BusGnt = 1;
    @(negedge clk);
    chk("rstw_req", BusReq, 1);
    @(posedge clk); #1;
    BusGnt = 0;
    @(negedge clk);
    chk("rstw_wait_stall", MemStall, 1);
    @(posedge clk); #1;
    rst = 1; MemReadM = 0;
    @(negedge clk);
    chk("rstw_still_wait", MemStall, 1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rstw_stall", MemStall, 0);
    chk("rstw_req2", BusReq, 0);
    chk("rstw_addr", BusAddr, 0);
    chk("rstw_ram", RamDataM, 32'h0);
    ram_model = 32'h0;
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      logic rd, wr, fl, er;
      logic [1:0] sz;
      logic [31:0] a, d, rdat;
      int gd, rv, es, nw;
      bit acc, trp;
      rd = 1'($urandom % 2);
      wr = ($urandom % 3) == 0;
      fl = ($urandom % 6) == 0;
      er = ($urandom % 8) == 0;
      sz = 2'($urandom);
      a = $urandom; d = $urandom; rdat = $urandom;
      gd = int'($urandom_range(0, 3));
      rv = int'($urandom_range(0, 5));
      acc = (rd | wr) & ~fl;
      trp = TRAP_EN && acc && m_misaligned(sz, a);
      nw = (rv >= TMO) ? TMO : rv + 1;
      es = (acc && !trp) ? (2 + gd + (wr ? 0 : nw)) : 0;
      run_access(rd, wr, sz, a, d, fl, gd, rv, rdat, er, sc, oa, os, ow, owe);
      chk($sformatf("rnd%0d_stall", n), sc, es);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory initiator. Takes the load/store carried in EX/MEM and issues it on a single-outstanding req/gnt/rvalid data bus. It generates byte strobes and replicated write data, and holds the pipeline stalled until the access completes. It then presents the raw 32-bit read word as RamDataM, which the MEM/WB register captures alongside AluOutM[1:0] for load realignment in WB.

Parameters:
TIMEOUT, 255, max cycles to wait for BusRValid after a read grant; 0 disables the timeout
RESET_RDATA, 32'h0000_0000, reset/flush value of RamDataM

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
MemReadM  in  1  load in MEM stage
MemWriteM  in  1  store in MEM stage
MemSizeM  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
FlushM  in  1  kill the MEM-stage access before issue
AluOutM  in  32  effective byte address
StoreDataM  in  32  rs2 store data, LSB-justified
RamDataM  out  32  raw aligned read word, registered
MemStall  out  1  hold IF..MEM; drives MEM/WB en low
MemErrM  out  1  one-cycle pulse: bus error, timeout, or misalign trap
BusReq  out  1  request valid
BusWe  out  1  1 = write
BusAddr  out  32  word address, [1:0] = 00
BusWStrb  out  4  byte enables
BusWData  out  32  write data
BusGnt  in  1  request accepted this cycle
BusRValid  in  1  read data valid
BusRData  in  32  read data
BusErr  in  1  error, sampled with BusGnt (writes) or BusRValid (reads)

Behaviour:
- Reset: state IDLE; RamDataM=RESET_RDATA; BusReq=0, BusWe=0, BusAddr=0, BusWStrb=0, BusWData=0; MemErrM=0; timeout counter=0.
- access = (MemReadM|MemWriteM) & ~FlushM. If both read and write are set, write wins.
- MemStall is combinational: (IDLE & access & ~trap) | REQ | WAIT. MemStall is 0 in DONE.
- IDLE, access: register bus fields and go to REQ.
  - BusAddr={AluOutM[31:2],2'b00}; BusWe=write.
  - Strobes: byte 4'b0001<<AluOutM[1:0]; half 4'b0011<<{AluOutM[1],1'b0}; word 4'b1111. Reads use the same strobes.
  - BusWData: byte {4{StoreDataM[7:0]}}; half {2{StoreDataM[15:0]}}; word StoreDataM.
- REQ: BusReq=1. Addr, data and strobes stay stable until BusGnt.
  - Gnt & write: go to DONE. MemErrM=BusErr.
  - Gnt & read: go to WAIT, clear the counter.
  - BusReq deasserts the cycle after the grant.
- WAIT: counter increments each cycle.
  - BusRValid: RamDataM<=BusRData (RESET_RDATA if BusErr), MemErrM=BusErr, go to DONE.
  - TIMEOUT!=0 and counter==TIMEOUT-1 without rvalid: MemErrM=1, RamDataM=RESET_RDATA, go to DONE.
  - A late rvalid in IDLE is ignored.
- DONE: one cycle, stall released so MEM/WB captures. Then IDLE. The instruction is not reissued, because the pipeline advances on that edge.
- Latency: store ≥3 cycles (IDLE, REQ, DONE). Load ≥4 cycles (IDLE, REQ, WAIT, DONE).
- FlushM is honoured only in IDLE. Once in REQ or WAIT the transaction completes; flush has no effect.
- rst in any state returns to IDLE next edge and drops BusReq. The bus side must tolerate an abandoned request.
- RamDataM holds its value outside captures.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) is a trap. No bus activity, no stall. MemErrM pulses for one cycle in IDLE, and RamDataM is unchanged.
- Undefined: misalignment is never trapped. The offending low address bits are cleared (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.

Test Plan:
- Word load at 0x100, gnt 1 cycle late, rvalid 2 cycles after gnt with 0xDEADBEEF -> BusAddr=0x100, BusWStrb=4'hF, MemStall high 5 cycles, RamDataM=0xDEADBEEF in DONE, MemErrM=0.
- Byte store 0xA5 to 0x203, gnt immediate -> BusAddr=0x200, BusWStrb=4'b1000, BusWData=0xA5A5A5A5, BusWe=1, MemStall high 2 cycles.
- Half store 0x1234 to 0x002, BusGnt held low 4 cycles -> request fields stable all 4 cycles, BusWStrb=4'b1100, BusWData=0x12341234.
- TIMEOUT=4, load with no rvalid -> MemErrM pulse after 4 WAIT cycles, RamDataM=0, stall released, next load works.
- Half load at 0x101: with MISALIGN_TRAP_EN, MemErrM=1 and BusReq never asserted. Without it, BusAddr=0x100, BusWStrb=4'b0011.
- FlushM with MemReadM in IDLE -> no request. rst asserted in WAIT -> next cycle IDLE, MemStall=0, BusReq=0.
